// File: rtl/count6_disp_if.sv
// count6_disp_if
//   Bundles the display stage's data path: the binary count coming in from
//   the counter stage and the multiplexed 7-segment drive going out.
//   Ports (signals):
//     cnt_in [5:0]  binary count 0..63 from the counter stage
//     seg    [7:0]  {dp,g,f,e,d,c,b,a} segment drive
//     dig    [1:0]  digit enables, dig[0]=ones, dig[1]=tens
//     busy          high while a BCD conversion is running
//   Modports:
//     master : counter side / testbench (drives cnt_in, observes outputs)
//     slave  : display stage (consumes cnt_in, drives seg/dig/busy)
interface count6_disp_if;
    logic [5:0] cnt_in;
    logic [7:0] seg;
    logic [1:0] dig;
    logic       busy;

    modport master (output cnt_in, input seg, input dig, input busy);
    modport slave  (input cnt_in, output seg, output dig, output busy);
endinterface

// File: rtl/count6_disp.sv
// count6_disp
//   Display stage behind the 6-bit loadable counter. The incoming count is
//   converted to two BCD digits by a sequential shift-add-3 FSM and shown on
//   a time-multiplexed pair of 7-segment digits.
//   Parameters:
//     SCAN_DIV       clk cycles each digit stays lit (2..2^20-1)
//     SEG_ACTIVE_LOW 1: seg/dig asserted low, 0: asserted high
//     BLANK_LZ       1: tens digit blanked when it is zero
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  synchronous reset, active-high
//     bus  count6_disp_if.slave (cnt_in in, seg/dig/busy out)
module count6_disp #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    count6_disp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0]  DIG_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 32'd1);

    // One double-dabble iteration on {tens[3:0], ones[3:0], bin[5:0]}:
    // correct each BCD nibble that would overflow past 9 on doubling, then shift.
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) begin
            t[13:10] = t[13:10] + 4'd3;
        end else begin
            t[13:10] = t[13:10];
        end
        if (t[9:6] >= 4'd5) begin
            t[9:6] = t[9:6] + 4'd3;
        end else begin
            t[9:6] = t[9:6];
        end
        return {t[12:0], 1'b0};
    endfunction

    // Active-high gfedcba pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    state_t      state_r, state_s;
    logic [5:0]  in_q_r;
    logic [5:0]  last_r, last_s;
    logic [5:0]  cap_r, cap_s;      // value captured at conversion start
    logic [13:0] sh_r, sh_s;
    logic [2:0]  it_r, it_s;
    logic [3:0]  tens_r, tens_s;
    logic [3:0]  ones_r, ones_s;
    logic        busy_r, busy_s;
    logic [19:0] div_r, div_s;
    logic        sel_r, sel_s;
    logic [7:0]  seg_r, seg_s;
    logic [1:0]  dig_r, dig_s;
    logic [7:0]  seg_raw_s;

    // Conversion FSM next-state and datapath updates.
    always_comb begin
        state_s = state_r;
        sh_s    = sh_r;
        it_s    = it_r;
        cap_s   = cap_r;
        tens_s  = tens_r;
        ones_s  = ones_r;
        last_s  = last_r;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (in_q_r != last_r) begin
                    sh_s    = {8'd0, in_q_r};
                    it_s    = 3'd0;
                    cap_s   = in_q_r;
                    busy_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // Six shifts, then one extra cycle here before handing off
                // to DONE so the result lands nine edges after sampling.
                if (it_r == 3'd6) begin
                    state_s = DONE;
                end else begin
                    sh_s    = dd_step(sh_r);
                    it_s    = it_r + 3'd1;
                    state_s = SHIFT;
                end
            end
            DONE: begin
                // Digits only ever change here, so no partial BCD is shown.
                tens_s  = sh_r[13:10];
                ones_s  = sh_r[9:6];
                last_s  = cap_r;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Scan divider, digit select and registered segment/digit drive.
    always_comb begin
        if (div_r == DIV_LAST) begin
            div_s = 20'd0;
            sel_s = ~sel_r;
        end else begin
            div_s = div_r + 20'd1;
            sel_s = sel_r;
        end

        if (sel_r) begin
            if (BLANK_LZ && (tens_r == 4'd0)) begin
                seg_raw_s = 8'h00;
            end else begin
                seg_raw_s = {1'b0, seg_decode(tens_r)};
            end
            dig_s = 2'b10;
        end else begin
            seg_raw_s = {1'b0, seg_decode(ones_r)};
            dig_s     = 2'b01;
        end

        if (SEG_ACTIVE_LOW) begin
            seg_s = ~seg_raw_s;
            dig_s = ~dig_s;
        end else begin
            seg_s = seg_raw_s;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            in_q_r  <= 6'd0;
            last_r  <= 6'd0;
            cap_r   <= 6'd0;
            sh_r    <= 14'd0;
            it_r    <= 3'd0;
            tens_r  <= 4'd0;
            ones_r  <= 4'd0;
            busy_r  <= 1'b0;
            div_r   <= 20'd0;
            sel_r   <= 1'b0;
            seg_r   <= SEG_OFF;
            dig_r   <= DIG_OFF;
        end else begin
            state_r <= state_s;
            in_q_r  <= bus.cnt_in;
            last_r  <= last_s;
            cap_r   <= cap_s;
            sh_r    <= sh_s;
            it_r    <= it_s;
            tens_r  <= tens_s;
            ones_r  <= ones_s;
            busy_r  <= busy_s;
            div_r   <= div_s;
            sel_r   <= sel_s;
            seg_r   <= seg_s;
            dig_r   <= dig_s;
        end
    end

    assign bus.seg  = seg_r;
    assign bus.dig  = dig_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_count6_disp.sv
// Testbench for count6_disp (SCAN_DIV=4, active-low drive, leading-zero
// blanking). A cycle-level reference model computes the expected display
// from decimal arithmetic and a fixed conversion delay.
module tb_count6_disp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count6_disp_if bus();

    count6_disp #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int m_inq, m_last, m_pend, m_timer, m_tens, m_ones, m_div;
    bit m_sel, m_busy;
    logic [7:0] m_seg;
    logic [1:0] m_dig;

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        logic [6:0] pat;
        if (rst) begin
            m_inq = 0; m_last = 0; m_pend = 0; m_timer = 0;
            m_tens = 0; m_ones = 0; m_div = 0; m_sel = 1'b0; m_busy = 1'b0;
            m_seg = 8'hFF; m_dig = 2'b11;
        end else begin
            if (m_sel) begin
                pat = (m_tens == 0) ? 7'h00 : segtab[m_tens];
                m_dig = 2'b01;
            end else begin
                pat = segtab[m_ones];
                m_dig = 2'b10;
            end
            m_seg = ~{1'b0, pat};
            // Conversion result appears 8 edges after the start decision.
            if (m_timer == 0) begin
                if (m_inq != m_last) begin
                    m_pend = m_inq; m_timer = 8; m_busy = 1'b1;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_tens = m_pend / 10; m_ones = m_pend % 10;
                    m_last = m_pend; m_busy = 1'b0;
                end
            end
            if (m_div == 3) begin
                m_div = 0; m_sel = ~m_sel;
            end else begin
                m_div++;
            end
            m_inq = int'(bus.cnt_in);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (model_on) begin
            chk("seg",  32'(bus.seg),  32'(m_seg));
            chk("dig",  32'(bus.dig),  32'(m_dig));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("tens", 32'(dut.tens_r), 32'(m_tens));
            chk("ones", 32'(dut.ones_r), 32'(m_ones));
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.cnt_in = 6'd0;
        rst = 1'b1;
        tick();
        model_on = 1'b1;
        tick();
        chk("rst_seg",  32'(bus.seg),  32'h0000_00FF);
        chk("rst_dig",  32'(bus.dig),  32'h0000_0003);
        chk("rst_busy", 32'(bus.busy), 32'h0000_0000);
        rst = 1'b0;
        tick();
        chk("first_dig", 32'(bus.dig), 32'h0000_0002);
        chk("first_seg", 32'(bus.seg), 32'h0000_00C0);
        hold(5);

        // 0 -> 37: digits settle nine edges after the sampling edge
        bus.cnt_in = 6'd37;
        hold(2);
        chk("busy37", 32'(bus.busy), 32'd1);
        hold(8);
        chk("t37_tens", 32'(dut.tens_r), 32'd3);
        chk("t37_ones", 32'(dut.ones_r), 32'd7);
        hold(12);

        bus.cnt_in = 6'd63;
        hold(20);
        bus.cnt_in = 6'd5;
        hold(20);

        // change during busy: second conversion follows the first
        bus.cnt_in = 6'd12;
        hold(3);
        bus.cnt_in = 6'd45;
        hold(30);
        chk("t45_tens", 32'(dut.tens_r), 32'd4);
        chk("t45_ones", 32'(dut.ones_r), 32'd5);

        // reset mid-conversion, then fresh conversion
        bus.cnt_in = 6'd20;
        hold(4);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        hold(11);
        chk("t20_tens", 32'(dut.tens_r), 32'd2);
        chk("t20_ones", 32'(dut.ones_r), 32'd0);

        // full sweep
        for (int v = 0; v < 64; v++) begin
            bus.cnt_in = 6'(v);
            hold(12);
            chk("sweep", 32'(dut.tens_r) * 32'd10 + 32'(dut.ones_r), 32'(v));
        end

        // randomized values, holds and occasional resets
        for (int k = 0; k < 250; k++) begin
            bus.cnt_in = 6'($urandom_range(0, 63));
            rst = ($urandom_range(0, 40) == 0);
            tick();
            rst = 1'b0;
            hold($urandom_range(0, 14));
        end
        hold(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
